// File: rtl/ramb_tdp_param_pkg.sv
// Shared definitions for the parametrised true dual-port block RAM:
// write-mode encodings, address-width helper and byte-lane merge.
package ramb_tdp_param_pkg;

    typedef enum logic [1:0] {
        WM_WRITE_FIRST = 2'd0,
        WM_READ_FIRST  = 2'd1,
        WM_NO_CHANGE   = 2'd2
    } write_mode_e;

    // Widest word the lane-merge helper handles; callers zero-extend into
    // it and truncate the result back to their own width.
    localparam int unsigned MAX_W = 1024;

    // Address width for a given depth, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Replace the lanes of old_w selected by we with the lanes of new_w.
    // Lane i covers bits [i*byte_w +: byte_w].
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_W-1:0] we,
        input int unsigned      byte_w
    );
        logic [MAX_W-1:0] lane_ones;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] w;
        lane_ones = '1;
        lane_ones = lane_ones >> (MAX_W - byte_w);
        mask      = '0;
        w         = we;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (w[0]) begin
                mask = mask | (lane_ones << (i * byte_w));
            end
            w = w >> 1;
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/ramb_tdp_param_port_out.sv
// Per-port output path: read latch with write-mode selection, optional
// output pipeline register, synchronous set/reset and async reset.
module ramb_port_out
    import ramb_tdp_param_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              WRITE_MODE = 0,
    parameter int              DO_REG     = 0,
    parameter logic [DATA_W-1:0] INIT     = '0,
    parameter logic [DATA_W-1:0] SRVAL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ssr,
    input  logic              regce,
    input  logic              we_any,
    input  logic [DATA_W-1:0] rd_old,
    input  logic [DATA_W-1:0] rd_new,
    output logic [DATA_W-1:0] dout
);

    localparam write_mode_e MODE = write_mode_e'(WRITE_MODE[1:0]);

    logic [DATA_W-1:0] lat;
    logic [DATA_W-1:0] do_q;

    // Read latch: SRVAL on SSR, plain read when not writing, else write mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= INIT;
        end else if (en) begin
            if (ssr) begin
                lat <= SRVAL;
            end else if (!we_any) begin
                lat <= rd_old;
            end else begin
                case (MODE)
                    WM_WRITE_FIRST: lat <= rd_new;
                    WM_READ_FIRST:  lat <= rd_old;
                    default:        lat <= lat;
                endcase
            end
        end
    end

    // Output pipeline register, loaded from the latch's previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_q <= INIT;
        end else if (regce) begin
            do_q <= (en && ssr) ? SRVAL : lat;
        end
    end

    assign dout = (DO_REG != 0) ? do_q : lat;

endmodule

// File: rtl/ramb_tdp_param.sv
// Parametrised single-clock true dual-port RAM with per-port write modes,
// optional output registers and a deterministic collision policy.
module ramb_tdp_param
    import ramb_tdp_param_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                BYTE_W       = 8,
    parameter int                DEPTH        = 1024,
    parameter int                WRITE_MODE_A = 0,
    parameter int                WRITE_MODE_B = 0,
    parameter int                DO_REG_A     = 0,
    parameter int                DO_REG_B     = 0,
    parameter logic [DATA_W-1:0] INIT_A       = '0,
    parameter logic [DATA_W-1:0] INIT_B       = '0,
    parameter logic [DATA_W-1:0] SRVAL_A      = '0,
    parameter logic [DATA_W-1:0] SRVAL_B      = '0,
    parameter logic [DATA_W-1:0] MEM_INIT     = '0,
    localparam int               NB           = DATA_W / BYTE_W,
    localparam int               ADDR_W       = int'(clog2(DEPTH))
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENA,
    input  logic [NB-1:0]     WEA,
    input  logic              SSRA,
    input  logic              REGCEA,
    input  logic [ADDR_W-1:0] ADDRA,
    input  logic [DATA_W-1:0] DIA,
    output logic [DATA_W-1:0] DOA,
    input  logic              ENB,
    input  logic [NB-1:0]     WEB,
    input  logic              SSRB,
    input  logic              REGCEB,
    input  logic [ADDR_W-1:0] ADDRB,
    input  logic [DATA_W-1:0] DIB,
    output logic [DATA_W-1:0] DOB,
    output logic              COLL
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Storage holds word XOR MEM_INIT, so a zero power-up array reads back
    // as the fill value without any initialisation process.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              va, vb, same;
    logic [NB-1:0]     wea_eff, web_eff;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b;

    // Pre-write reads and post-write words; on a shared address B is merged
    // first and A on top, so A owns every lane it enables.
    always_comb begin
        va      = ({1'b0, ADDRA} < DEPTH_L);
        vb      = ({1'b0, ADDRB} < DEPTH_L);
        same    = (ADDRA == ADDRB);
        old_a   = va ? (mem[ADDRA] ^ MEM_INIT) : '0;
        old_b   = vb ? (mem[ADDRB] ^ MEM_INIT) : '0;
        wea_eff = (ENA && va && !RST) ? WEA : '0;
        web_eff = (ENB && vb && !RST) ? WEB : '0;
        new_b   = DATA_W'(lane_merge(MAX_W'(old_b), MAX_W'(DIB), MAX_W'(web_eff), BYTE_W));
        if (same) begin
            new_a = DATA_W'(lane_merge(MAX_W'(new_b), MAX_W'(DIA), MAX_W'(wea_eff), BYTE_W));
            new_b = new_a;
        end else begin
            new_a = DATA_W'(lane_merge(MAX_W'(old_a), MAX_W'(DIA), MAX_W'(wea_eff), BYTE_W));
        end
    end

    // Memory array writes; contents survive reset.
    always_ff @(posedge CLK) begin
        if (|wea_eff) begin
            mem[ADDRA] <= new_a ^ MEM_INIT;
        end
        if (|web_eff) begin
            mem[ADDRB] <= new_b ^ MEM_INIT;
        end
    end

    // Collision flag: both enabled, same address, at least one writing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COLL <= 1'b0;
        end else begin
            COLL <= ENA && ENB && same && ((|WEA) || (|WEB));
        end
    end

    ramb_port_out #(
        .DATA_W    (DATA_W),
        .WRITE_MODE(WRITE_MODE_A),
        .DO_REG    (DO_REG_A),
        .INIT      (INIT_A),
        .SRVAL     (SRVAL_A)
    ) u_port_a (
        .clk   (CLK),
        .rst   (RST),
        .en    (ENA),
        .ssr   (SSRA),
        .regce (REGCEA),
        .we_any(|WEA),
        .rd_old(old_a),
        .rd_new(new_a),
        .dout  (DOA)
    );

    ramb_port_out #(
        .DATA_W    (DATA_W),
        .WRITE_MODE(WRITE_MODE_B),
        .DO_REG    (DO_REG_B),
        .INIT      (INIT_B),
        .SRVAL     (SRVAL_B)
    ) u_port_b (
        .clk   (CLK),
        .rst   (RST),
        .en    (ENB),
        .ssr   (SSRB),
        .regce (REGCEB),
        .we_any(|WEB),
        .rd_old(old_b),
        .rd_new(new_b),
        .dout  (DOB)
    );

endmodule

// File: tb/tb_ramb_tdp_param.sv
// Scoreboard bench for ramb_tdp_param: two instances with different write
// modes and output registers share one stimulus stream and one memory model.
module tb_ramb_tdp_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena, enb, ssra, ssrb, regcea, regceb;
    logic [1:0]  wea, web;
    logic [4:0]  addra, addrb;
    logic [15:0] dia, dib;
    logic [15:0] doa0, dob0, doa1, dob1;
    logic        coll0, coll1;

    // next-cycle stimulus
    logic        s_rst, s_ena, s_enb, s_ssra, s_ssrb, s_regcea, s_regceb;
    logic [1:0]  s_wea, s_web;
    logic [4:0]  s_addra, s_addrb;
    logic [15:0] s_dia, s_dib;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        coll;
    } exp_t;
    exp_t q[$];
    bit   started = 0;

    always #5 clk = ~clk;

    ramb_tdp_param #(
        .DATA_W(16), .BYTE_W(8), .DEPTH(20),
        .WRITE_MODE_A(0), .WRITE_MODE_B(1), .DO_REG_A(0), .DO_REG_B(0),
        .INIT_A(16'hA5A5), .INIT_B(16'h5A5A), .SRVAL_A(16'h0F0F), .SRVAL_B(16'hF0F0),
        .MEM_INIT(16'h0000)
    ) u0 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WEA(wea), .SSRA(ssra), .REGCEA(regcea), .ADDRA(addra), .DIA(dia), .DOA(doa0),
        .ENB(enb), .WEB(web), .SSRB(ssrb), .REGCEB(regceb), .ADDRB(addrb), .DIB(dib), .DOB(dob0),
        .COLL(coll0)
    );

    ramb_tdp_param #(
        .DATA_W(16), .BYTE_W(8), .DEPTH(20),
        .WRITE_MODE_A(2), .WRITE_MODE_B(0), .DO_REG_A(1), .DO_REG_B(1),
        .INIT_A(16'h0001), .INIT_B(16'h0002), .SRVAL_A(16'h3C3C), .SRVAL_B(16'hC3C3),
        .MEM_INIT(16'h0000)
    ) u1 (
        .CLK(clk), .RST(rst),
        .ENA(ena), .WEA(wea), .SSRA(ssra), .REGCEA(regcea), .ADDRA(addra), .DIA(dia), .DOA(doa1),
        .ENB(enb), .WEB(web), .SSRB(ssrb), .REGCEB(regceb), .ADDRB(addrb), .DIB(dib), .DOB(dob1),
        .COLL(coll1)
    );

    // ---------------- reference model ----------------
    // index k: 0 u0 port A, 1 u0 port B, 2 u1 port A, 3 u1 port B
    logic [15:0] m_mem [32];
    int          wm  [4] = '{0, 1, 2, 0};
    bit          dr  [4] = '{0, 0, 1, 1};
    logic [15:0] ini [4] = '{16'hA5A5, 16'h5A5A, 16'h0001, 16'h0002};
    logic [15:0] srv [4] = '{16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3};
    logic [15:0] lat [4];
    logic [15:0] dq  [4];
    logic        m_coll;

    function automatic logic [15:0] mrd(input logic [4:0] a);
        return (a < 5'd20) ? m_mem[a] : 16'h0000;
    endfunction

    task automatic model_step();
        logic        en_p [2];
        logic        ssr_p[2];
        logic        ce_p [2];
        logic [1:0]  we_p [2];
        logic [4:0]  ad_p [2];
        logic [15:0] di_p [2];
        logic [15:0] oldw [2];
        logic [15:0] post [2];
        logic [15:0] prev;
        int          p;
        en_p = '{ena, enb};   ssr_p = '{ssra, ssrb}; ce_p = '{regcea, regceb};
        we_p = '{wea, web};   ad_p  = '{addra, addrb}; di_p = '{dia, dib};
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                lat[k] = ini[k];
                dq[k]  = ini[k];
            end
            m_coll = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) oldw[i] = mrd(ad_p[i]);
            // port B written first so port A's lanes win on a shared address
            for (int i = 1; i >= 0; i--) begin
                if (en_p[i] && ad_p[i] < 5'd20) begin
                    for (int l = 0; l < 2; l++) begin
                        if (we_p[i][l]) m_mem[ad_p[i]][l*8 +: 8] = di_p[i][l*8 +: 8];
                    end
                end
            end
            for (int i = 0; i < 2; i++) post[i] = mrd(ad_p[i]);
            for (int k = 0; k < 4; k++) begin
                p    = k % 2;
                prev = lat[k];
                if (en_p[p]) begin
                    if (ssr_p[p])            lat[k] = srv[k];
                    else if (we_p[p] == 0)   lat[k] = oldw[p];
                    else if (wm[k] == 0)     lat[k] = post[p];
                    else if (wm[k] == 1)     lat[k] = oldw[p];
                end
                if (dr[k]) begin
                    if (ce_p[p]) dq[k] = (en_p[p] && ssr_p[p]) ? srv[k] : prev;
                end else begin
                    dq[k] = lat[k];
                end
            end
            m_coll = ena && enb && (addra == addrb) && ((wea != 0) || (web != 0));
        end
        q.push_back('{dq[0], dq[1], dq[2], dq[3], m_coll});
        started = 1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // monitor: one expected record per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_doa0", doa0, e.a0);
                chk("sb_dob0", dob0, e.b0);
                chk("sb_doa1", doa1, e.a1);
                chk("sb_dob1", dob1, e.b1);
                chk("sb_coll0", {15'b0, coll0}, {15'b0, e.coll});
                chk("sb_coll1", {15'b0, coll1}, {15'b0, e.coll});
            end else if (started) begin
                chk("sb_queue_empty", 16'd0, 16'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        s_ena = 0; s_enb = 0; s_wea = 0; s_web = 0; s_ssra = 0; s_ssrb = 0;
        s_regcea = 1; s_regceb = 1; s_addra = 0; s_addrb = 0; s_dia = 0; s_dib = 0;
    endtask

    task automatic apply();
        @(negedge clk);
        rst = s_rst; ena = s_ena; enb = s_enb; wea = s_wea; web = s_web;
        ssra = s_ssra; ssrb = s_ssrb; regcea = s_regcea; regceb = s_regceb;
        addra = s_addra; addrb = s_addrb; dia = s_dia; dib = s_dib;
        model_step();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic cycle();
        apply();
        finish_cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
        ena = 0; enb = 0; wea = 0; web = 0; ssra = 0; ssrb = 0;
        regcea = 1; regceb = 1; addra = 0; addrb = 0; dia = 0; dib = 0;
        #1 rst = 1'b1;
        #1;
        chk("reset_doa0", doa0, 16'hA5A5);
        chk("reset_dob0", dob0, 16'h5A5A);
        chk("reset_doa1", doa1, 16'h0001);
        chk("reset_dob1", dob1, 16'h0002);
        chk("reset_coll", {15'b0, coll0}, 16'd0);

        idle(); s_rst = 1; cycle();
        s_rst = 0;

        // write modes
        idle(); s_ena = 1; s_wea = 2'b11; s_addra = 5'd4; s_dia = 16'hBEEF; cycle();
        chk("wf_first_write", doa0, 16'hBEEF);
        idle(); s_ena = 1; s_addra = 5'd4; s_enb = 1; s_addrb = 5'd4; cycle();
        chk("read_b_beef", dob0, 16'hBEEF);
        idle(); s_ena = 1; s_addra = 5'd4; cycle();
        chk("doreg_beef", doa1, 16'hBEEF);
        idle(); s_ena = 1; s_wea = 2'b11; s_addra = 5'd5; s_dia = 16'h1234;
        s_enb = 1; s_web = 2'b11; s_addrb = 5'd6; s_dib = 16'h1234; cycle();
        chk("write_first", doa0, 16'h1234);
        chk("read_first", dob0, 16'h0000);
        chk("no_change", doa1, 16'hBEEF);

        // asynchronous reset in the middle of a read
        idle(); s_ena = 1; s_addra = 5'd5; s_rst = 1; apply();
        #1;
        chk("async_reset_doa0", doa0, 16'hA5A5);
        chk("async_reset_doa1", doa1, 16'h0001);
        finish_cycle();
        s_rst = 0;
        idle(); s_ena = 1; s_addra = 5'd3; cycle();
        chk("read_after_reset", doa0, 16'h0000);
        idle(); s_ena = 1; s_addra = 5'd5; cycle();
        chk("mem_kept_over_reset", doa0, 16'h1234);

        // byte enables
        idle(); s_ena = 1; s_wea = 2'b11; s_addra = 5'd7; s_dia = 16'hAAAA; cycle();
        idle(); s_ena = 1; s_wea = 2'b01; s_addra = 5'd7; s_dia = 16'h5555; cycle();
        idle(); s_ena = 1; s_addra = 5'd7; cycle();
        chk("byte_enable", doa0, 16'hAA55);

        // write-write collision
        idle(); s_ena = 1; s_wea = 2'b10; s_addra = 5'd9; s_dia = 16'h1111;
        s_enb = 1; s_web = 2'b11; s_addrb = 5'd9; s_dib = 16'h2222; cycle();
        chk("coll_pulse0", {15'b0, coll0}, 16'd1);
        chk("coll_pulse1", {15'b0, coll1}, 16'd1);
        idle(); s_ena = 1; s_addra = 5'd9; cycle();
        chk("coll_one_cycle", {15'b0, coll0}, 16'd0);
        chk("coll_merge", doa0, 16'h1122);
        idle(); s_ena = 1; s_wea = 2'b10; s_addra = 5'd10; s_dia = 16'h1111;
        s_enb = 1; s_web = 2'b11; s_addrb = 5'd11; s_dib = 16'h2222; cycle();
        chk("no_coll_diff_addr", {15'b0, coll0}, 16'd0);

        // output register latency and REGCE hold
        idle(); s_enb = 1; s_web = 2'b11; s_addrb = 5'd2; s_dib = 16'h00C3; cycle();
        idle(); s_ena = 1; s_addra = 5'd2; cycle();
        idle(); cycle();
        chk("doreg_second_edge", doa1, 16'h00C3);
        idle(); s_ena = 1; s_addra = 5'd4; s_regcea = 0; cycle();
        idle(); s_regcea = 0; cycle();
        chk("regce_hold", doa1, 16'h00C3);

        // SSR with a concurrent write
        idle(); s_ena = 1; s_ssra = 1; s_wea = 2'b11; s_addra = 5'd12; s_dia = 16'h7777; cycle();
        chk("ssr_latch", doa0, 16'h0F0F);
        chk("ssr_doreg", doa1, 16'h3C3C);
        idle(); s_ena = 1; s_addra = 5'd12; cycle();
        chk("ssr_write_done", doa0, 16'h7777);

        // address beyond DEPTH
        idle(); s_ena = 1; s_wea = 2'b11; s_addra = 5'd25; s_dia = 16'hFFFF; cycle();
        chk("oob_write_first", doa0, 16'h0000);
        idle(); s_ena = 1; s_addra = 5'd25; cycle();
        chk("oob_read", doa0, 16'h0000);
        idle(); s_ena = 1; s_addra = 5'd5; cycle();
        chk("oob_no_alias", doa0, 16'h1234);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            s_rst    = ($urandom_range(0, 199) == 0);
            s_ena    = !s_rst && ($urandom_range(0, 3) != 0);
            s_enb    = !s_rst && ($urandom_range(0, 3) != 0);
            s_wea    = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
            s_web    = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
            s_ssra   = s_ena && ($urandom_range(0, 15) == 0);
            s_ssrb   = s_enb && ($urandom_range(0, 15) == 0);
            s_regcea = ($urandom_range(0, 3) != 0);
            s_regceb = ($urandom_range(0, 3) != 0);
            s_addra  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            s_addrb  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            s_dia    = 16'($urandom);
            s_dib    = 16'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
